uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- Synthesizable target side of the UART program-download link used by the FPU_Bfloat testbenches.
- Receives 8N1 bytes on a serial line and packs every 4 bytes MSB-first into a 32-bit word.
- Writes each word into instruction memory at incrementing word addresses.
- Stops on the end marker 32'h00000FFF and signals completion. It also drives the ready flag that the host waits on before it starts sending.

Parameters:
- CLKS_PER_BIT, 347, clock cycles per UART bit (40 MHz / 115200 baud).
- ADDR_W, 12, word-address width.
- DEPTH, 4096, words of instruction memory (16384 bytes).
- END_MARKER, 32'h00000FFF, terminating word.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- prog_en_i  in  1  enables loading; while low, rx is ignored and prog_ready_o is low.
- rx_i  in  1  UART serial input; idle high.
- prog_ready_o  out  1  loader armed and waiting for or receiving data.
- mem_we_o  out  1  one-cycle instruction-memory write strobe.
- mem_addr_o  out  ADDR_W  word address of the write.
- mem_wdata_o  out  32  word data, first received byte in [31:24].
- prog_done_o  out  1  sticky; END_MARKER received.
- frame_err_o  out  1  sticky; a stop bit was sampled low.
- overflow_o  out  1  sticky; a word arrived after DEPTH words were already written.

Behaviour:
- Reset: all outputs 0; byte count 0; address 0; FSM in IDLE; synchronizer flops set to 1.
- rx_i passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- prog_ready_o = prog_en_i & ~prog_done_o, registered. It goes high the cycle after reset release when prog_en_i is high.
- RX FSM:
  - IDLE: on synchronized rx = 0 → START, counter cleared.
  - START: at CLKS_PER_BIT/2 cycles, resample. If rx = 0 → DATA. If rx = 1 (glitch) → IDLE.
  - DATA: sample every CLKS_PER_BIT cycles. Bits arrive LSB first. After 8 bits → STOP.
  - STOP: sample after CLKS_PER_BIT. If rx = 1, pulse byte_valid for 1 cycle. If rx = 0, set frame_err_o and discard the byte. In both cases → IDLE.
- Start bits stretched up to +12% of a bit (the host lengthens the start bit by 1 us) must still decode correctly. Mid-bit sampling after the start edge provides this margin.
- Word packing:
  - On each byte_valid: word <= {word[23:0], byte}; byte_cnt increments modulo 4.
  - When the 4th byte is accepted, the following cycle does exactly one of:
    - If the word equals END_MARKER: set prog_done_o. No write.
    - Else if address < DEPTH: mem_we_o = 1 for exactly one cycle, with mem_addr_o = address and mem_wdata_o = word. Address then increments.
    - Else: set overflow_o. No write; the address does not wrap.
- Latency: mem_we_o asserts 1 cycle after the byte_valid of the 4th byte.
- After prog_done_o, received bytes are discarded. The FSM still frames them, so frame_err_o can still set.
- A frame error does not advance byte_cnt. A partial word stays pending.
- prog_en_i falling mid-byte: the FSM finishes the current byte and discards it. byte_cnt resets to 0. Address is retained.
- Asynchronous reset mid-byte or mid-word aborts everything to reset state on the same edge. No write is issued.
- mem_addr_o and mem_wdata_o hold their last values when mem_we_o is low.

Decomposition:
- Shared package fpu_prog_pkg holds:
  - END_MARKER
  - default CLKS_PER_BIT
  - RX FSM state enum (IDLE/START/DATA/STOP)
- One sub-module, uart_rx_core, covers the synchronizer, RX FSM and bit counter.
  - Outputs: byte_o[7:0], byte_valid_o, frame_err_o.
  - uart_prog_loader instantiates it and adds packing, addressing and status flags.

Test Plan:
- Reset release with prog_en_i = 1 and rx idle → all outputs 0 during reset. prog_ready_o = 1 one cycle after release. No mem_we_o for 10 bit-times.
- Send bytes DE AD BE EF (start bit +1 us) → exactly one mem_we_o pulse, mem_addr_o = 0, mem_wdata_o = 32'hDEADBEEF, 1 cycle after the last stop-bit sample.
- Send 3 words, then 00 00 0F FF → writes at addresses 0, 1, 2 with the correct data. prog_done_o = 1 and prog_ready_o = 0. Further bytes cause no writes.
- Byte 0x55 with stop bit driven 0, then 11 22 33 44 → frame_err_o = 1. The next write has data 32'h11223344: the bad byte is dropped and the word stays aligned.
- DEPTH overridden to 2, send 3 non-marker words → 2 writes at addresses 0 and 1. Third word: overflow_o = 1 and no mem_we_o.
- Assert wb_rst_i after 2 bytes of a word, release, then send A1 B2 C3 D4 → write at address 0 with data 32'hA1B2C3D4. No stale bytes are included.

Source files
------------

// File: rtl/fpu_prog_pkg.sv
// Shared constants and types for the UART program loader.
// The RX state enum is shared by the loader and its receive core.
package fpu_prog_pkg;

    localparam int          DEFAULT_CLKS_PER_BIT = 347;
    localparam logic [31:0] END_MARKER           = 32'h00000FFF;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the program loader.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 12
) ();

    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;

    modport master (output mem_we_o, mem_addr_o, mem_wdata_o);
    modport slave  (input  mem_we_o, mem_addr_o, mem_wdata_o);

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle byte strobe.
module uart_rx_core
    import fpu_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int             CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    // [0],[1] synchronize; [2] holds the previous synchronized value for edge detection
    logic [2:0]       sync_reg;
    logic             rx_s;
    logic             rx_prev;

    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;

    assign rx_s    = sync_reg[1];
    assign rx_prev = sync_reg[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= 3'b111;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[1:0], rx};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            // A falling edge is required so a low stop bit cannot retrigger a start.
            IDLE: begin
                if (en && !rx_s && rx_prev) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == HALF_M1) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    valid_next = rx_s;
                    ferr_next  = !rx_s;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign byte_o       = shift_reg;
    assign byte_valid_o = valid_reg;
    assign frame_err_o  = ferr_reg;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes MSB-first into words and writes them
// to instruction memory until the end marker arrives.
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = fpu_prog_pkg::DEFAULT_CLKS_PER_BIT,
    parameter int          ADDR_W       = 12,
    parameter int          DEPTH        = 4096,
    parameter logic [31:0] END_MARKER   = fpu_prog_pkg::END_MARKER
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     prog_en_i,
    input  logic                     rx_i,
    output logic                     prog_ready_o,
    uart_prog_loader_if.master       mem,
    output logic                     prog_done_o,
    output logic                     frame_err_o,
    output logic                     overflow_o
);
    import fpu_prog_pkg::*;

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ferr;

    // One extra address bit so the DEPTH limit is detectable without wrapping
    logic [ADDR_W:0]   addr_reg;
    logic [23:0]       word_reg;
    logic [1:0]        byte_cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_out_reg;
    logic [31:0]       wdata_reg;
    logic              done_reg;
    logic              ferr_reg;
    logic              ovf_reg;
    logic              ready_reg;

    logic              accept;
    logic              last_byte;
    logic              in_range;
    logic [31:0]       full_word;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .en           (prog_en_i),
        .rx           (rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    always_comb begin
        accept    = rx_valid && prog_en_i && !done_reg;
        full_word = {word_reg, rx_byte};
        last_byte = accept && (byte_cnt_reg == 2'd3);
        in_range  = addr_reg < (ADDR_W + 1)'(DEPTH);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            addr_reg     <= '0;
            word_reg     <= '0;
            byte_cnt_reg <= '0;
            we_reg       <= 1'b0;
            addr_out_reg <= '0;
            wdata_reg    <= '0;
            done_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            ready_reg <= prog_en_i && !done_reg;
            we_reg    <= 1'b0;

            if (!prog_en_i) begin
                byte_cnt_reg <= '0;
            end else if (accept) begin
                word_reg     <= full_word[23:0];
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end

            if (last_byte) begin
                if (full_word == END_MARKER) begin
                    done_reg <= 1'b1;
                end else if (in_range) begin
                    we_reg       <= 1'b1;
                    addr_out_reg <= addr_reg[ADDR_W-1:0];
                    wdata_reg    <= full_word;
                    addr_reg     <= addr_reg + (ADDR_W + 1)'(1);
                end else begin
                    ovf_reg <= 1'b1;
                end
            end

            if (rx_ferr && prog_en_i) begin
                ferr_reg <= 1'b1;
            end
        end
    end

    assign mem.mem_we_o    = we_reg;
    assign mem.mem_addr_o  = addr_out_reg;
    assign mem.mem_wdata_o = wdata_reg;
    assign prog_ready_o    = ready_reg;
    assign prog_done_o     = done_reg;
    assign frame_err_o     = ferr_reg;
    assign overflow_o      = ovf_reg;

endmodule
